// File: rtl/ac_dr_datapath_if.sv
// Bus/control bundle between the control unit (master) and the AC/DR datapath (slave).
interface ac_dr_datapath_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned INPR_WIDTH = 8
);
  // Control unit -> datapath
  logic [WIDTH-1:0]      BUS_IN;
  logic                  LoadDR;
  logic                  INRDR;
  logic                  CLRDR;
  logic                  LoadAC;
  logic                  INRAC;
  logic                  CLRAC;
  logic                  AND;
  logic                  ADD;
  logic                  LDA;
  logic                  COM;
  logic                  SHR;
  logic                  SHL;
  logic                  INPT;
  logic [INPR_WIDTH-1:0] INPR;
  logic                  CLE;
  logic                  CME;

  // Datapath -> control unit / bus
  logic [WIDTH-1:0]      AC_OUT;
  logic [WIDTH-1:0]      DR_OUT;
  logic                  E_OUT;
  logic [WIDTH-1:0]      ACDATA;
  logic                  COUT;
  logic                  AC_ZERO;
  logic                  AC_NEG;
  logic                  DR_ZERO;

  modport master (
    output BUS_IN, LoadDR, INRDR, CLRDR, LoadAC, INRAC, CLRAC,
           AND, ADD, LDA, COM, SHR, SHL, INPT, INPR, CLE, CME,
    input  AC_OUT, DR_OUT, E_OUT, ACDATA, COUT, AC_ZERO, AC_NEG, DR_ZERO
  );

  modport slave (
    input  BUS_IN, LoadDR, INRDR, CLRDR, LoadAC, INRAC, CLRAC,
           AND, ADD, LDA, COM, SHR, SHL, INPT, INPR, CLE, CME,
    output AC_OUT, DR_OUT, E_OUT, ACDATA, COUT, AC_ZERO, AC_NEG, DR_ZERO
  );
endinterface

// File: rtl/ac_dr_datapath.sv
// Accumulator-side datapath: DR, AC, E flip-flop and the combinational AC ALU.
module ac_dr_datapath #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned INPR_WIDTH = 8
) (
  input logic              CLK,
  input logic              CLR,
  ac_dr_datapath_if.slave  dp
);

  typedef enum logic [2:0] {
    OpNone,
    OpAnd,
    OpAdd,
    OpLda,
    OpCom,
    OpShr,
    OpShl,
    OpInpt
  } alu_op_e;

  logic [WIDTH-1:0] dr_q, dr_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic             e_q, e_d;

  alu_op_e          alu_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;

  // Full-width sum; the top bit is the carry the control unit and E see.
  assign sum = {1'b0, ac_q} + {1'b0, dr_q};

  // Resolve op selects by fixed priority; the control unit normally drives them one-hot.
  always_comb begin
    alu_op = OpNone;
    if (dp.AND)       alu_op = OpAnd;
    else if (dp.ADD)  alu_op = OpAdd;
    else if (dp.LDA)  alu_op = OpLda;
    else if (dp.COM)  alu_op = OpCom;
    else if (dp.SHR)  alu_op = OpShr;
    else if (dp.SHL)  alu_op = OpShl;
    else if (dp.INPT) alu_op = OpInpt;
  end

  // ALU result from the pre-edge register contents.
  always_comb begin
    alu_res = ac_q;
    unique case (alu_op)
      OpAnd:   alu_res = ac_q & dr_q;
      OpAdd:   alu_res = sum[WIDTH-1:0];
      OpLda:   alu_res = dr_q;
      OpCom:   alu_res = ~ac_q;
      OpShr:   alu_res = {e_q, ac_q[WIDTH-1:1]};
      OpShl:   alu_res = {ac_q[WIDTH-2:0], e_q};
      OpInpt:  alu_res = {ac_q[WIDTH-1:INPR_WIDTH], dp.INPR};
      default: alu_res = ac_q;
    endcase
  end

  // DR next state: clear > load > increment > hold.
  always_comb begin
    dr_d = dr_q;
    if (dp.CLRDR)       dr_d = '0;
    else if (dp.LoadDR) dr_d = dp.BUS_IN;
    else if (dp.INRDR)  dr_d = dr_q + WIDTH'(1);
  end

  // AC next state: clear > ALU load > increment > hold.
  always_comb begin
    ac_d = ac_q;
    if (dp.CLRAC)       ac_d = '0;
    else if (dp.LoadAC) ac_d = alu_res;
    else if (dp.INRAC)  ac_d = ac_q + WIDTH'(1);
  end

  // E next state: ADD/SHR/SHL loads capture carry or shifted-out bit, else CLE > CME.
  always_comb begin
    e_d = e_q;
    if (dp.LoadAC && alu_op == OpAdd)      e_d = sum[WIDTH];
    else if (dp.LoadAC && alu_op == OpShr) e_d = ac_q[0];
    else if (dp.LoadAC && alu_op == OpShl) e_d = ac_q[WIDTH-1];
    else if (dp.CLE)                       e_d = 1'b0;
    else if (dp.CME)                       e_d = ~e_q;
  end

  // Register update; CLR overrides every other control.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      dr_q <= '0;
      ac_q <= '0;
      e_q  <= 1'b0;
    end else begin
      dr_q <= dr_d;
      ac_q <= ac_d;
      e_q  <= e_d;
    end
  end

  assign dp.AC_OUT  = ac_q;
  assign dp.DR_OUT  = dr_q;
  assign dp.E_OUT   = e_q;
  assign dp.ACDATA  = alu_res;
  assign dp.COUT    = sum[WIDTH];
  assign dp.AC_ZERO = (ac_q == '0);
  assign dp.AC_NEG  = ac_q[WIDTH-1];
  assign dp.DR_ZERO = (dr_q == '0);

endmodule

// File: tb/tb_ac_dr_datapath.sv
// Self-checking bench for ac_dr_datapath: directed steps plus randomized controls vs a model.
module tb_ac_dr_datapath;

  logic CLK;
  logic CLR;

  ac_dr_datapath_if #(.WIDTH(16), .INPR_WIDTH(8)) dp ();

  ac_dr_datapath #(.WIDTH(16), .INPR_WIDTH(8)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .dp  (dp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference state
  int unsigned m_ac;
  int unsigned m_dr;
  int unsigned m_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    CLR       = 1'b0;
    dp.BUS_IN = '0;
    dp.LoadDR = 0; dp.INRDR = 0; dp.CLRDR = 0;
    dp.LoadAC = 0; dp.INRAC = 0; dp.CLRAC = 0;
    dp.AND = 0; dp.ADD = 0; dp.LDA = 0; dp.COM = 0;
    dp.SHR = 0; dp.SHL = 0; dp.INPT = 0;
    dp.INPR = '0;
    dp.CLE = 0; dp.CME = 0;
  endtask

  // Index 0..6 = AND, ADD, LDA, COM, SHR, SHL, INPT
  task automatic drive_ops(input logic [6:0] o);
    dp.AND = o[0]; dp.ADD = o[1]; dp.LDA = o[2]; dp.COM = o[3];
    dp.SHR = o[4]; dp.SHL = o[5]; dp.INPT = o[6];
  endtask

  // First asserted op in priority order, 0 if none.
  function automatic int sel_op();
    logic [6:0] o;
    o = {dp.INPT, dp.SHL, dp.SHR, dp.COM, dp.LDA, dp.ADD, dp.AND};
    for (int i = 0; i < 7; i++) if (o[i]) return i + 1;
    return 0;
  endfunction

  function automatic int unsigned model_alu();
    case (sel_op())
      1: return m_ac & m_dr;
      2: return (m_ac + m_dr) % 65536;
      3: return m_dr;
      4: return 65535 - m_ac;
      5: return (m_e * 32768) + (m_ac / 2);
      6: return ((m_ac * 2) % 65536) + m_e;
      7: return (m_ac / 256) * 256 + dp.INPR;
      default: return m_ac;
    endcase
  endfunction

  // Check combinational outputs, clock once, advance the model and check registered state.
  task automatic tick();
    int unsigned res, carry, op;
    int unsigned n_ac, n_dr, n_e;
    #1;
    res   = model_alu();
    carry = (m_ac + m_dr) / 65536;
    op    = sel_op();
    check("ACDATA", 32'(dp.ACDATA), res);
    check("COUT", 32'(dp.COUT), carry);

    n_dr = dp.CLRDR ? 0 : dp.LoadDR ? dp.BUS_IN : dp.INRDR ? (m_dr + 1) % 65536 : m_dr;
    n_ac = dp.CLRAC ? 0 : dp.LoadAC ? res : dp.INRAC ? (m_ac + 1) % 65536 : m_ac;
    if (dp.LoadAC && op == 2)      n_e = carry;
    else if (dp.LoadAC && op == 5) n_e = m_ac % 2;
    else if (dp.LoadAC && op == 6) n_e = m_ac / 32768;
    else if (dp.CLE)               n_e = 0;
    else if (dp.CME)               n_e = 1 - m_e;
    else                           n_e = m_e;
    if (CLR) begin
      n_ac = 0; n_dr = 0; n_e = 0;
    end

    @(posedge CLK);
    #1;
    m_ac = n_ac; m_dr = n_dr; m_e = n_e;
    check("AC_OUT", 32'(dp.AC_OUT), m_ac);
    check("DR_OUT", 32'(dp.DR_OUT), m_dr);
    check("E_OUT", 32'(dp.E_OUT), m_e);
    check("AC_ZERO", 32'(dp.AC_ZERO), (m_ac == 0) ? 1 : 0);
    check("AC_NEG", 32'(dp.AC_NEG), m_ac / 32768);
    check("DR_ZERO", 32'(dp.DR_ZERO), (m_dr == 0) ? 1 : 0);
    idle();
  endtask

  task automatic load_dr(input logic [15:0] v);
    dp.BUS_IN = v; dp.LoadDR = 1; tick();
  endtask

  task automatic load_ac(input logic [15:0] v);
    load_dr(v);
    dp.LDA = 1; dp.LoadAC = 1; tick();
  endtask

  initial begin
    int r;
    logic [6:0] o;
    idle();
    m_ac = 0; m_dr = 0; m_e = 0;

    // Initial reset
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    check("rst_ac", 32'(dp.AC_OUT), 0);
    check("rst_dr", 32'(dp.DR_OUT), 0);
    check("rst_e", 32'(dp.E_OUT), 0);

    // CLR overrides loads and CME
    load_ac(16'h1234);
    dp.CME = 1; tick();
    check("pre_clr_e", 32'(dp.E_OUT), 1);
    CLR = 1; dp.BUS_IN = 16'h5555; dp.LoadDR = 1; dp.LDA = 1; dp.LoadAC = 1; dp.CME = 1;
    tick();
    check("clr_ac", 32'(dp.AC_OUT), 0);
    check("clr_dr", 32'(dp.DR_OUT), 0);
    check("clr_e", 32'(dp.E_OUT), 0);
    check("clr_acz", 32'(dp.AC_ZERO), 1);
    check("clr_drz", 32'(dp.DR_ZERO), 1);

    // Add with carry out into E
    load_ac(16'hFFFF);
    load_dr(16'h0002);
    dp.ADD = 1; dp.LoadAC = 1;
    #1 check("add_cout", 32'(dp.COUT), 1);
    tick();
    check("add_ac", 32'(dp.AC_OUT), 16'h0001);
    check("add_e", 32'(dp.E_OUT), 1);
    dp.ADD = 1; dp.LoadAC = 1; tick();
    check("add2_ac", 32'(dp.AC_OUT), 16'h0003);
    check("add2_e", 32'(dp.E_OUT), 0);

    // Logic ops and load
    load_ac(16'hF0F0);
    load_dr(16'h0FF0);
    dp.AND = 1; dp.LoadAC = 1; tick();
    check("and_ac", 32'(dp.AC_OUT), 16'h00F0);
    dp.COM = 1; dp.LoadAC = 1; tick();
    check("com_ac", 32'(dp.AC_OUT), 16'hFF0F);
    check("com_neg", 32'(dp.AC_NEG), 1);
    dp.LDA = 1; dp.LoadAC = 1; tick();
    check("lda_ac", 32'(dp.AC_OUT), 16'h0FF0);

    // Circulate through E
    load_ac(16'h8001);
    dp.CLE = 1; tick();
    dp.SHR = 1; dp.LoadAC = 1; tick();
    check("shr_ac", 32'(dp.AC_OUT), 16'h4000);
    check("shr_e", 32'(dp.E_OUT), 1);
    dp.SHL = 1; dp.LoadAC = 1; tick();
    check("shl_ac", 32'(dp.AC_OUT), 16'h8001);
    check("shl_e", 32'(dp.E_OUT), 0);

    // Input character and wrap-around increments
    load_ac(16'hAB00);
    dp.INPR = 8'h5A; dp.INPT = 1; dp.LoadAC = 1; tick();
    check("inpt_ac", 32'(dp.AC_OUT), 16'hAB5A);
    load_dr(16'hFFFF);
    dp.INRDR = 1; tick();
    check("inrdr_dr", 32'(dp.DR_OUT), 0);
    check("inrdr_z", 32'(dp.DR_ZERO), 1);
    load_ac(16'hFFFF);
    dp.INRAC = 1; tick();
    check("inrac_ac", 32'(dp.AC_OUT), 0);

    // Priority and same-cycle DR/AC interaction
    load_dr(16'h0007);
    dp.CLRAC = 1; dp.LDA = 1; dp.LoadAC = 1; tick();
    check("clrac_ac", 32'(dp.AC_OUT), 0);
    dp.BUS_IN = 16'h0009; dp.LoadDR = 1; dp.LDA = 1; dp.LoadAC = 1; tick();
    check("olddr_ac", 32'(dp.AC_OUT), 16'h0007);
    check("olddr_dr", 32'(dp.DR_OUT), 16'h0009);

    // Randomized controls against the model
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      o = '0;
      if (r <= 6) o[r] = 1'b1;
      else if (r >= 8) begin
        o[$urandom_range(0, 6)] = 1'b1;
        o[$urandom_range(0, 6)] = 1'b1;
      end
      drive_ops(o);
      dp.BUS_IN = 16'($urandom);
      dp.INPR   = 8'($urandom);
      dp.LoadDR = ($urandom_range(0, 3) == 0);
      dp.INRDR  = ($urandom_range(0, 3) == 0);
      dp.CLRDR  = ($urandom_range(0, 15) == 0);
      dp.LoadAC = ($urandom_range(0, 1) == 0);
      dp.INRAC  = ($urandom_range(0, 3) == 0);
      dp.CLRAC  = ($urandom_range(0, 15) == 0);
      dp.CLE    = ($urandom_range(0, 5) == 0);
      dp.CME    = ($urandom_range(0, 3) == 0);
      CLR       = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
